// File: rtl/utt_pkg.sv
// Shared types and helpers for the tap-game note lane engine.
// Holds the engine state encoding, pixel colours and saturating arithmetic.
package utt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_REDRAW,
    ST_DONE
  } state_e;

  localparam logic [2:0] COL_NOTE  = 3'b111;
  localparam logic [2:0] COL_EMPTY = 3'b000;

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned max_v);
    return (a + b > max_v) ? max_v : a + b;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (b > a) ? 32'd0 : a - b;
  endfunction

endpackage

// File: rtl/lane_judge.sv
// Per-lane press judge: rising-edge detect on the button, hit flag for the
// current bottom note, and hit / wrong / miss strobes for the engine to sum.
module lane_judge (
  input  logic clk,
  input  logic rst_n,
  input  logic press_i,
  input  logic note_i,
  input  logic judge_en_i,
  input  logic step_i,
  input  logic clear_i,
  output logic hit_o,
  output logic wrong_o,
  output logic miss_o
);

  logic hist_q;
  logic hit_q;
  logic press_edge;

  assign press_edge = press_i & ~hist_q;
  assign hit_o      = judge_en_i & press_edge & note_i & ~hit_q;
  assign wrong_o    = judge_en_i & press_edge & ~note_i;
  // A note hit in the same cycle as the step is not also a miss.
  assign miss_o     = step_i & note_i & ~hit_q & ~hit_o;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      hist_q <= press_i;
      if (clear_i || step_i) begin
        hit_q <= 1'b0;
      end else if (hit_o) begin
        hit_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_lane_engine.sv
// Multi-lane note engine: shifts note patterns on each step tick, judges presses
// at the hit row, keeps score/combo, and streams a redraw over valid/ready.
module note_lane_engine
  import utt_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DEPTH      = 100,
  parameter int VIEW       = 16,
  parameter int SCORE_W    = 10,
  parameter int MAX_SCORE  = 999,
  parameter int LANE_X0    = 20,
  parameter int LANE_PITCH = 30,
  parameter int Y_BOTTOM   = 110,
  parameter int ROW_PITCH  = 6
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     step_tick,
  input  logic                     running,
  input  logic [LANES-1:0]         press,
  input  logic [LANES*DEPTH-1:0]   pattern,
  output logic [SCORE_W-1:0]       score,
  output logic [SCORE_W-1:0]       combo,
  output logic                     done,
  output logic                     tick_overrun,
  output logic [7:0]               plot_x,
  output logic [7:0]               plot_y,
  output logic [2:0]               plot_colour,
  output logic                     plot_valid,
  input  logic                     plot_ready
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RW = (VIEW > 1) ? $clog2(VIEW) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = $clog2(LANES + 1);

  state_e             state_q;
  logic [DEPTH-1:0]   lanes_q [LANES];
  logic [DEPTH-1:0]   lanes_sh [LANES];
  logic [SCORE_W-1:0] score_q, combo_q;
  logic [SCORE_W-1:0] score_d, combo_d;
  logic               done_q, pending_q, overrun_q;
  logic [CW-1:0]      step_cnt_q;
  logic [LW-1:0]      lane_q, nxt_lane;
  logic [RW-1:0]      row_q, nxt_row;
  logic               fin_q, last_pix;
  logic [7:0]         x_q, y_q;
  logic [2:0]         col_q;
  logic               valid_q;

  logic               judge_en, step_go, clr_hits;
  logic [LANES-1:0]   note_v, hit_v, wrong_v, miss_v;
  logic [HW-1:0]      n_hit, n_wrong;
  int                 net;

  function automatic logic [7:0] pix_x(input logic [LW-1:0] lane);
    return 8'(LANE_X0 + int'(lane) * LANE_PITCH);
  endfunction

  function automatic logic [7:0] pix_y(input logic [RW-1:0] row);
    return 8'(Y_BOTTOM - int'(row) * ROW_PITCH);
  endfunction

  function automatic logic [2:0] pix_col(input logic [DEPTH-1:0] v, input logic [RW-1:0] row);
    return v[row] ? COL_NOTE : COL_EMPTY;
  endfunction

  assign judge_en = running && (state_q == ST_RUN || state_q == ST_REDRAW);
  assign step_go  = running && (state_q == ST_RUN) && (step_tick || pending_q);
  assign clr_hits = (state_q == ST_IDLE);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign note_v[l] = lanes_q[l][0];
    lane_judge u_judge (
      .clk        (clk),
      .rst_n      (resetn),
      .press_i    (press[l]),
      .note_i     (note_v[l]),
      .judge_en_i (judge_en),
      .step_i     (step_go),
      .clear_i    (clr_hits),
      .hit_o      (hit_v[l]),
      .wrong_o    (wrong_v[l]),
      .miss_o     (miss_v[l])
    );
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    n_hit   = '0;
    n_wrong = '0;
    for (int l = 0; l < LANES; l++) begin
      n_hit      = n_hit + HW'(hit_v[l]);
      n_wrong    = n_wrong + HW'(wrong_v[l]);
      lanes_sh[l] = lanes_q[l] >> 1;
    end
    // Same-cycle presses are netted before clamping, not applied one by one.
    net = int'(n_hit) - int'(n_wrong);
    if (net >= 0) begin
      score_d = SCORE_W'(sat_add(32'(score_q), unsigned'(net), unsigned'(MAX_SCORE)));
    end else begin
      score_d = SCORE_W'(sat_sub(32'(score_q), unsigned'(-net)));
    end
    if ((|wrong_v) || (|miss_v)) begin
      combo_d = '0;
    end else begin
      combo_d = SCORE_W'(sat_add(32'(combo_q), 32'(n_hit), unsigned'(MAX_SCORE)));
    end
  end

  always_comb begin
    last_pix = (lane_q == LW'(LANES - 1)) && (row_q == RW'(VIEW - 1));
    nxt_lane = lane_q;
    nxt_row  = row_q + 1'b1;
    if (row_q == RW'(VIEW - 1)) begin
      nxt_row  = '0;
      nxt_lane = lane_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      // NOTE: the lane shift registers are reset like any flop so play always starts clean.
      for (int l = 0; l < LANES; l++) lanes_q[l] <= '0;
      score_q    <= '0;
      combo_q    <= '0;
      done_q     <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      step_cnt_q <= '0;
      lane_q     <= '0;
      row_q      <= '0;
      fin_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          for (int l = 0; l < LANES; l++) lanes_q[l] <= pattern[l*DEPTH +: DEPTH];
          score_q    <= '0;
          combo_q    <= '0;
          done_q     <= 1'b0;
          pending_q  <= 1'b0;
          step_cnt_q <= '0;
          fin_q      <= 1'b0;
          valid_q    <= 1'b0;
          if (running) state_q <= ST_RUN;
        end
        ST_RUN: begin
          score_q <= score_d;
          combo_q <= combo_d;
          if (step_go) begin
            for (int l = 0; l < LANES; l++) lanes_q[l] <= lanes_sh[l];
            pending_q  <= 1'b0;
            if (step_tick && pending_q) overrun_q <= 1'b1;
            step_cnt_q <= step_cnt_q + 1'b1;
            if (step_cnt_q == CW'(DEPTH - 1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_REDRAW;
              lane_q  <= '0;
              row_q   <= '0;
              fin_q   <= 1'b0;
              x_q     <= pix_x('0);
              y_q     <= pix_y('0);
              col_q   <= pix_col(lanes_sh[0], '0);
              valid_q <= 1'b1;
            end
          end
        end
        ST_REDRAW: begin
          score_q <= score_d;
          combo_q <= combo_d;
          if (running && step_tick) begin
            if (pending_q) overrun_q <= 1'b1;
            else           pending_q <= 1'b1;
          end
          // An accept while paused still completes; the next pixel waits for resume.
          if (valid_q && plot_ready) begin
            if (last_pix) begin
              valid_q <= 1'b0;
              if (running) state_q <= ST_RUN;
              else         fin_q   <= 1'b1;
            end else begin
              lane_q  <= nxt_lane;
              row_q   <= nxt_row;
              x_q     <= pix_x(nxt_lane);
              y_q     <= pix_y(nxt_row);
              col_q   <= pix_col(lanes_q[nxt_lane], nxt_row);
              valid_q <= running;
            end
          end else if (!valid_q && running) begin
            if (fin_q) begin
              fin_q   <= 1'b0;
              state_q <= ST_RUN;
            end else begin
              valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!running) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign score        = score_q;
  assign combo        = combo_q;
  assign done         = done_q;
  assign tick_overrun = overrun_q;
  assign plot_x       = x_q;
  assign plot_y       = y_q;
  assign plot_colour  = col_q;
  assign plot_valid   = valid_q;

endmodule

// File: tb/tb_note_lane_engine.sv
// Directed bench for note_lane_engine: 4 lanes, 8-step patterns, 4 visible rows,
// score/combo saturating at 15 so the clamp is reachable within one game.
module tb_note_lane_engine;

  localparam int LANES     = 4;
  localparam int DEPTH     = 8;
  localparam int VIEW      = 4;
  localparam int SCORE_W   = 10;
  localparam int MAX_SCORE = 15;

  logic                   clk = 1'b0;
  logic                   resetn = 1'b0;
  logic                   step_tick = 1'b0;
  logic                   running = 1'b0;
  logic                   plot_ready = 1'b1;
  logic [LANES-1:0]       press = '0;
  logic [LANES*DEPTH-1:0] pattern;
  logic [SCORE_W-1:0]     score, combo;
  logic                   done, tick_overrun, plot_valid;
  logic [7:0]             plot_x, plot_y;
  logic [2:0]             plot_colour;

  int errors = 0;
  int checks = 0;

  // Lane patterns, bit 0 reaches the hit row first.
  logic [7:0] pat [LANES] = '{8'hFF, 8'hFE, 8'h08, 8'hD8};

  always #5 clk = ~clk;

  note_lane_engine #(
    .LANES(LANES), .DEPTH(DEPTH), .VIEW(VIEW), .SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .step_tick    (step_tick),
    .running      (running),
    .press        (press),
    .pattern      (pattern),
    .score        (score),
    .combo        (combo),
    .done         (done),
    .tick_overrun (tick_overrun),
    .plot_x       (plot_x),
    .plot_y       (plot_y),
    .plot_colour  (plot_colour),
    .plot_valid   (plot_valid),
    .plot_ready   (plot_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_sc(input string tag, input int exp_score, input int exp_combo);
    check({tag, " score"}, 32'(score), exp_score);
    check({tag, " combo"}, 32'(combo), exp_combo);
  endtask

  task automatic do_press(input logic [LANES-1:0] m);
    press = m;
    @(negedge clk);
    press = '0;
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    step_tick = 1'b1;
    @(negedge clk);
    step_tick = 1'b0;
  endtask

  task automatic check_pixel(input int n, input int shift);
    int lane, row;
    logic [7:0] v;
    lane = n / VIEW;
    row  = n % VIEW;
    v    = pat[lane] >> shift;
    check($sformatf("valid s%0d p%0d", shift, n), 32'(plot_valid), 1);
    check($sformatf("x s%0d p%0d", shift, n), 32'(plot_x), 20 + 30 * lane);
    check($sformatf("y s%0d p%0d", shift, n), 32'(plot_y), 110 - 6 * row);
    check($sformatf("colour s%0d p%0d", shift, n), 32'(plot_colour), v[row] ? 7 : 0);
  endtask

  // Checks pixels n0..n1-1 with plot_ready high; each negedge shows the next pixel.
  task automatic drain(input int shift, input int n0, input int n1);
    for (int n = n0; n < n1; n++) begin
      int t = 0;
      while (!plot_valid && t < 40) begin
        @(negedge clk);
        t++;
      end
      check_pixel(n, shift);
      @(negedge clk);
    end
  endtask

  initial begin
    pattern = {pat[3], pat[2], pat[1], pat[0]};
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    check_sc("reset", 0, 0);
    check("reset done", 32'(done), 0);
    check("reset overrun", 32'(tick_overrun), 0);
    check("reset valid", 32'(plot_valid), 0);
    check("reset x", 32'(plot_x), 0);
    pulse_tick();
    check("idle tick ignored", 32'(plot_valid), 0);

    // Game 1: scoring walk through all eight steps.
    running = 1'b1;
    @(negedge clk);
    do_press(4'b0100); check_sc("wrong at zero", 0, 0);
    do_press(4'b0001); check_sc("first hit", 1, 1);
    do_press(4'b0001); check_sc("repeat ignored", 1, 1);
    pulse_tick();      check_sc("hit not missed", 1, 1);
    drain(1, 0, 16);
    check("redraw end valid", 32'(plot_valid), 0);

    do_press(4'b0011); check_sc("two hits", 3, 3);
    pulse_tick(); drain(2, 0, 16);
    do_press(4'b0011); check_sc("two hits b", 5, 5);
    do_press(4'b0100); check_sc("wrong at five", 4, 0);
    pulse_tick(); drain(3, 0, 16);
    do_press(4'b1011); check_sc("three hits", 7, 3);
    pulse_tick();      check_sc("miss lane2", 7, 0);
    drain(4, 0, 16);
    do_press(4'b1011); check_sc("build combo", 10, 3);
    pulse_tick();      check_sc("no miss", 10, 3);
    drain(5, 0, 16);
    do_press(4'b0111); check_sc("hit hit wrong", 11, 0);
    pulse_tick(); drain(6, 0, 16);
    do_press(4'b1011); check_sc("near max", 14, 3);
    pulse_tick(); drain(7, 0, 16);
    do_press(4'b0001); check_sc("reach max", 15, 4);
    do_press(4'b0010); check_sc("sat hit", 15, 5);
    do_press(4'b1000); check_sc("sat hit b", 15, 6);
    pulse_tick();
    check("done after 8", 32'(done), 1);
    check("no redraw at done", 32'(plot_valid), 0);
    pulse_tick();
    check_sc("done hold", 15, 6);
    check("done tick ignored", 32'(plot_valid), 0);
    running = 1'b0;
    @(negedge clk);
    check("done cleared", 32'(done), 0);
    @(negedge clk);
    check_sc("idle cleared", 0, 0);

    // Game 2: back-pressure, lost tick, then reset mid-draw.
    running = 1'b1;
    @(negedge clk);
    do_press(4'b0001); check_sc("g2 hit", 1, 1);
    pulse_tick();
    drain(1, 0, 5);
    plot_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_tick = (i == 0 || i == 2);
      @(negedge clk);
      step_tick = 1'b0;
      check_pixel(5, 1);
      check($sformatf("overrun stall %0d", i), 32'(tick_overrun), (i >= 2) ? 1 : 0);
    end
    plot_ready = 1'b1;
    drain(1, 5, 16);
    check("g2 redraw end valid", 32'(plot_valid), 0);
    drain(2, 0, 16);
    check_sc("pending step miss", 1, 0);
    pulse_tick();
    drain(3, 0, 3);
    #2 resetn = 1'b0;
    #1;
    check("async reset valid", 32'(plot_valid), 0);
    check_sc("async reset", 0, 0);
    check("async reset overrun", 32'(tick_overrun), 0);
    check("async reset done", 32'(done), 0);
    running = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    pulse_tick();
    check("post reset idle", 32'(plot_valid), 0);
    running = 1'b1;
    @(negedge clk);
    pulse_tick();
    drain(1, 0, 16);
    check("final redraw end", 32'(plot_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
